// File: rtl/vga_test_pattern.sv
// VGA test-pattern generator: colour bars, grey gradient, checkerboard and
// horizontally scrolling bars, registered with one cycle of latency.
// The pattern mode is latched only at frame start so a frame is never torn.
// Optional feature macro: VGA_TEST_PATTERN_SCROLL_EN (builds the scroll
// offset registers; without it mode 3 renders the same as mode 0).
module vga_test_pattern #(
    parameter int H_VISIBLE     = 640,
    parameter int H_WHOLE_LINE  = 800,
    parameter int V_VISIBLE     = 480,
    parameter int V_WHOLE_FRAME = 525,
    parameter int COLOR_BITS    = 4,
    parameter int NUM_BARS      = 8,
    parameter int CHECK_SHIFT   = 5,
    parameter int SCROLL_STEP   = 2
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [$clog2(H_WHOLE_LINE)-1:0]      column,
    input  logic [$clog2(V_WHOLE_FRAME)-1:0]     row,
    input  logic [1:0]                           mode,
    output logic [COLOR_BITS-1:0]                red,
    output logic [COLOR_BITS-1:0]                green,
    output logic [COLOR_BITS-1:0]                blue,
    output logic                                 frame_end
);

    localparam int CW     = $clog2(H_WHOLE_LINE);
    localparam int RW     = $clog2(V_WHOLE_FRAME);
    localparam int BAR_W  = H_VISIBLE / NUM_BARS;
    localparam int GRAD_W = H_VISIBLE >> COLOR_BITS;
    localparam int SW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int BW     = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int GW     = (GRAD_W > 1) ? $clog2(GRAD_W) : 1;

    localparam logic [CW-1:0]         H_VIS_C   = CW'(H_VISIBLE);
    localparam logic [CW-1:0]         H_LAST_C  = CW'(H_WHOLE_LINE - 1);
    localparam logic [RW-1:0]         V_VIS_C   = RW'(V_VISIBLE);
    localparam logic [RW-1:0]         V_LAST_C  = RW'(V_WHOLE_FRAME - 1);
    localparam logic [SW-1:0]         SUB_LAST  = SW'(BAR_W - 1);
    localparam logic [BW-1:0]         BAR_LAST  = BW'(NUM_BARS - 1);
    localparam logic [GW-1:0]         GRAD_LAST = GW'(GRAD_W - 1);
    localparam logic [COLOR_BITS-1:0] FULL      = '1;

    typedef enum logic [1:0] {
        MODE_BARS   = 2'd0,
        MODE_GRAD   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_e;

    if ((H_VISIBLE % NUM_BARS) != 0) begin : g_bad_bar_split
        $error("H_VISIBLE must be divisible by NUM_BARS");
    end
    if (SCROLL_STEP >= BAR_W) begin : g_bad_scroll_step
        $error("SCROLL_STEP must be smaller than H_VISIBLE/NUM_BARS");
    end
    if (GRAD_W < 1) begin : g_bad_grad_width
        $error("H_VISIBLE too small for the gradient level count");
    end

    mode_e                 r_mode_q;
    logic [SW-1:0]         r_sub;
    logic [BW-1:0]         r_bar;
    logic [GW-1:0]         r_gcnt;
    logic [COLOR_BITS-1:0] r_level;

    logic                  w_line_start;
    logic                  w_frame_start;
    logic                  w_frame_last;
    logic                  w_col_vis;
    logic                  w_visible;
    mode_e                 w_mode_eff;
    logic [SW-1:0]         w_pre_sub;
    logic [BW-1:0]         w_pre_bar;
    logic [SW-1:0]         w_sub_cur;
    logic [BW-1:0]         w_bar_cur;
    logic [GW-1:0]         w_gcnt_cur;
    logic [COLOR_BITS-1:0] w_level_cur;
    logic [2:0]            w_c;
    logic [COLOR_BITS-1:0] w_red, w_green, w_blue;

    assign w_line_start  = (column == '0);
    assign w_frame_start = w_line_start && (row == '0);
    assign w_frame_last  = (column == H_LAST_C) && (row == V_LAST_C);
    assign w_col_vis     = (column < H_VIS_C);
    assign w_visible     = w_col_vis && (row < V_VIS_C);
    // The first pixel of a frame already uses the freshly requested mode.
    assign w_mode_eff    = w_frame_start ? mode_e'(mode) : r_mode_q;

`ifdef VGA_TEST_PATTERN_SCROLL_EN
    logic [SW-1:0] r_scroll_sub;
    logic [BW-1:0] r_scroll_bar;
    logic [SW:0]   w_scroll_sum;

    assign w_scroll_sum = {1'b0, r_scroll_sub} + (SW+1)'(SCROLL_STEP);
    assign w_pre_sub    = (w_mode_eff == MODE_SCROLL) ? r_scroll_sub : '0;
    assign w_pre_bar    = (w_mode_eff == MODE_SCROLL) ? r_scroll_bar : '0;

    // Advance the scroll offset once per frame, in every mode.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_scroll_sub <= '0;
            r_scroll_bar <= '0;
        end else if (w_frame_last) begin
            if (w_scroll_sum >= (SW+1)'(BAR_W)) begin
                r_scroll_sub <= SW'(w_scroll_sum - (SW+1)'(BAR_W));
                r_scroll_bar <= (r_scroll_bar == BAR_LAST) ? '0 : r_scroll_bar + 1'b1;
            end else begin
                r_scroll_sub <= SW'(w_scroll_sum);
            end
        end
    end
`else
    assign w_pre_sub = '0;
    assign w_pre_bar = '0;
`endif

    assign w_sub_cur   = w_line_start ? w_pre_sub : r_sub;
    assign w_bar_cur   = w_line_start ? w_pre_bar : r_bar;
    assign w_gcnt_cur  = w_line_start ? '0 : r_gcnt;
    assign w_level_cur = w_line_start ? '0 : r_level;
    assign w_c         = 3'd7 - 3'(w_bar_cur);

    // Latch the requested mode at frame start only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_mode_q <= MODE_BARS;
        end else if (w_frame_start) begin
            r_mode_q <= mode_e'(mode);
        end
    end

    // Bar and gradient position counters, re-seeded at each line start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sub   <= '0;
            r_bar   <= '0;
            r_gcnt  <= '0;
            r_level <= '0;
        end else if (w_col_vis) begin
            if (w_sub_cur == SUB_LAST) begin
                r_sub <= '0;
                r_bar <= (w_bar_cur == BAR_LAST) ? '0 : w_bar_cur + 1'b1;
            end else begin
                r_sub <= w_sub_cur + 1'b1;
                r_bar <= w_bar_cur;
            end
            if (w_gcnt_cur == GRAD_LAST) begin
                r_gcnt  <= '0;
                r_level <= (w_level_cur == FULL) ? w_level_cur : w_level_cur + 1'b1;
            end else begin
                r_gcnt  <= w_gcnt_cur + 1'b1;
                r_level <= w_level_cur;
            end
        end
    end

    // Pixel colour selection; blanking forces black in every mode.
    always_comb begin
        w_red   = '0;
        w_green = '0;
        w_blue  = '0;
        if (w_visible) begin
            unique case (w_mode_eff)
                MODE_GRAD: begin
                    w_red   = w_level_cur;
                    w_green = w_level_cur;
                    w_blue  = w_level_cur;
                end
                MODE_CHECK: begin
                    if (column[CHECK_SHIFT] ^ row[CHECK_SHIFT]) begin
                        w_red   = FULL;
                        w_green = FULL;
                        w_blue  = FULL;
                    end
                end
                default: begin
                    w_green = w_c[2] ? FULL : '0;
                    w_red   = w_c[1] ? FULL : '0;
                    w_blue  = w_c[0] ? FULL : '0;
                end
            endcase
        end
    end

    // Output register: one cycle of latency for colour and frame_end.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            frame_end <= 1'b0;
        end else begin
            red       <= w_red;
            green     <= w_green;
            blue      <= w_blue;
            frame_end <= w_frame_last;
        end
    end

endmodule
